// File: rtl/move_history_board.sv
// rtl/move_history_board.sv - tic-tac-toe board with per-player vanishing-move history FIFOs
// Optional TURN_CHECK_EN adds turn tracking and the turn output.
module move_history_board #(
    parameter int CELLS = 9,
    parameter int PW    = 4,
    parameter int DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 mv_valid,
    input  logic                 mv_player,
    input  logic [PW-1:0]        mv_pos,
    output logic                 mv_ready,
    output logic                 mv_done,
    output logic                 mv_reject,
    output logic                 evict_valid,
    output logic [PW-1:0]        evict_pos,
    output logic [2*CELLS-1:0]   board,
    output logic [3:0]           o_count,
    output logic [3:0]           x_count
`ifdef TURN_CHECK_EN
    ,
    output logic                 turn
`endif
);

    typedef enum logic {IDLE, COMMIT} state_t;

    localparam logic [2:0] LAST = 3'(DEPTH - 1);

    state_t         state, state_next;
    logic           cur_player;
    logic [PW-1:0]  cur_pos;
    logic [PW-1:0]  hist [2][DEPTH];
    logic [2:0]     head [2];
    logic [2:0]     tail [2];
    logic [3:0]     cnt  [2];

    logic           in_range, occupied, turn_ok, accept, legal;
    logic [2:0]     head_sel, tail_sel;
    logic [3:0]     cnt_sel;
    logic [PW-1:0]  evict_cell;
    logic           full;

    function automatic logic [2:0] wrap(input logic [2:0] p);
        return (p == LAST) ? 3'd0 : p + 3'd1;
    endfunction

    // Range and occupancy looked up by compare so out-of-range positions never index the board
    always_comb begin
        in_range = 1'b0;
        occupied = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            if (mv_pos == PW'(i)) begin
                in_range = 1'b1;
                occupied = (board[2*i +: 2] != 2'b00);
            end
        end
    end

`ifdef TURN_CHECK_EN
    assign turn_ok = (mv_player == turn);
`else
    assign turn_ok = 1'b1;
`endif

    assign accept  = mv_valid & mv_ready;
    assign legal   = in_range & ~occupied & turn_ok;
    assign o_count = cnt[0];
    assign x_count = cnt[1];

    always_comb begin
        state_next = state;
        mv_ready   = 1'b0;
        case (state)
            IDLE: begin
                mv_ready = ~clear;
                if (accept && legal)
                    state_next = COMMIT;
            end
            COMMIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear)
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        head_sel   = head[cur_player];
        tail_sel   = tail[cur_player];
        cnt_sel    = cnt[cur_player];
        evict_cell = '0;
        for (int k = 0; k < DEPTH; k++)
            if (head_sel == 3'(k))
                evict_cell = hist[cur_player][k];
        full = (cnt_sel == 4'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            board       <= '0;
            mv_done     <= 1'b0;
            mv_reject   <= 1'b0;
            evict_valid <= 1'b0;
            evict_pos   <= '0;
            cur_player  <= 1'b0;
            cur_pos     <= '0;
            for (int p = 0; p < 2; p++) begin
                head[p] <= '0;
                tail[p] <= '0;
                cnt[p]  <= '0;
                for (int k = 0; k < DEPTH; k++)
                    hist[p][k] <= '0;
            end
`ifdef TURN_CHECK_EN
            turn <= 1'b0;
`endif
        end else begin
            mv_done     <= 1'b0;
            mv_reject   <= 1'b0;
            evict_valid <= 1'b0;
            if (clear) begin
                board     <= '0;
                evict_pos <= '0;
                for (int p = 0; p < 2; p++) begin
                    head[p] <= '0;
                    tail[p] <= '0;
                    cnt[p]  <= '0;
                end
`ifdef TURN_CHECK_EN
                turn <= 1'b0;
`endif
            end else if (state == IDLE) begin
                if (accept) begin
                    if (legal) begin
                        cur_player <= mv_player;
                        cur_pos    <= mv_pos;
                    end else begin
                        mv_reject <= 1'b1;
                    end
                end
            end else begin
                mv_done <= 1'b1;
                // Evicted cell is never the new cell, so both writes can land in one update
                for (int i = 0; i < CELLS; i++) begin
                    if (full && evict_cell == PW'(i))
                        board[2*i +: 2] <= 2'b00;
                    if (cur_pos == PW'(i))
                        board[2*i +: 2] <= cur_player ? 2'b10 : 2'b01;
                end
                for (int k = 0; k < DEPTH; k++)
                    if (tail_sel == 3'(k))
                        hist[cur_player][k] <= cur_pos;
                tail[cur_player] <= wrap(tail_sel);
                if (full) begin
                    head[cur_player] <= wrap(head_sel);
                    evict_valid      <= 1'b1;
                    evict_pos        <= evict_cell;
                end else begin
                    cnt[cur_player] <= cnt_sel + 4'd1;
                end
`ifdef TURN_CHECK_EN
                turn <= ~turn;
`endif
            end
        end
    end

endmodule

// File: tb/tb_move_history_board.sv
// tb/tb_move_history_board.sv - scoreboard bench for move_history_board (CELLS=9, DEPTH=3)
module tb_move_history_board;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        mv_valid = 1'b0;
    logic        mv_player = 1'b0;
    logic [3:0]  mv_pos = '0;
    logic        mv_ready, mv_done, mv_reject, evict_valid;
    logic [3:0]  evict_pos;
    logic [17:0] board;
    logic [3:0]  o_count, x_count;
`ifdef TURN_CHECK_EN
    logic        turn;
`endif

    typedef struct {
        bit          rej;
        bit          ev;
        logic [3:0]  evp;
        logic [17:0] brd;
        logic [3:0]  oc;
        logic [3:0]  xc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   errors  = 0;

    move_history_board #(.CELLS(9), .PW(4), .DEPTH(3)) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .mv_valid(mv_valid),
        .mv_player(mv_player),
        .mv_pos(mv_pos),
        .mv_ready(mv_ready),
        .mv_done(mv_done),
        .mv_reject(mv_reject),
        .evict_valid(evict_valid),
        .evict_pos(evict_pos),
        .board(board),
        .o_count(o_count),
        .x_count(x_count)
`ifdef TURN_CHECK_EN
        ,
        .turn(turn)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && (mv_done || mv_reject || evict_valid)) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_pulse: got done=%0b reject=%0b evict=%0b, required none",
                         mv_done, mv_reject, evict_valid);
            end else begin
                e = sb.pop_front();
                chk("pulse_reject", 32'(mv_reject), 32'(e.rej));
                chk("pulse_done", 32'(mv_done), 32'(!e.rej));
                chk("evict_valid", 32'(evict_valid), 32'(e.ev));
                if (e.ev)
                    chk("evict_pos", 32'(evict_pos), 32'(e.evp));
                chk("board", 32'(board), 32'(e.brd));
                chk("o_count", 32'(o_count), 32'(e.oc));
                chk("x_count", 32'(x_count), 32'(e.xc));
            end
        end
    end

    task automatic move(input bit p, input logic [3:0] pos, input bit rej, input bit ev,
                        input logic [3:0] evp, input logic [17:0] brd,
                        input logic [3:0] oc, input logic [3:0] xc);
        int   n = 0;
        exp_t x;
        @(negedge clk);
        mv_valid  = 1'b1;
        mv_player = p;
        mv_pos    = pos;
        while (!mv_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!mv_ready) begin
            vectors++;
            errors++;
            $display("FAIL ready_timeout: got mv_ready=0, required 1");
        end
        x.rej = rej; x.ev = ev; x.evp = evp; x.brd = brd; x.oc = oc; x.xc = xc;
        sb.push_back(x);
        @(posedge clk);
        #1 mv_valid = 1'b0;
        if (!rej) begin
            @(negedge clk);
            chk("ready_busy", 32'(mv_ready), 32'd0);
        end
    endtask

    task automatic pulse_clear(input bit with_valid);
        @(negedge clk);
        clear     = 1'b1;
        mv_valid  = with_valid;
        mv_player = 1'b0;
        mv_pos    = 4'd5;
        @(posedge clk);
        #1 clear = 1'b0;
        mv_valid = 1'b0;
        @(negedge clk);
        chk("clear_board", 32'(board), 32'd0);
        chk("clear_counts", 32'({o_count, x_count}), 32'd0);
    endtask

    initial begin
        int n;
        @(negedge clk);
        chk("rst_board", 32'(board), 32'd0);
        chk("rst_counts", 32'({o_count, x_count}), 32'd0);
        chk("rst_ready", 32'(mv_ready), 32'd1);
        chk("rst_pulses", 32'({mv_done, mv_reject, evict_valid}), 32'd0);
        chk("rst_evict_pos", 32'(evict_pos), 32'd0);
        rst = 1'b1;

        move(0, 4, 0, 0, 0, 18'h00100, 1, 0);
        move(1, 4, 1, 0, 0, 18'h00100, 1, 0);
        move(0, 9, 1, 0, 0, 18'h00100, 1, 0);
        pulse_clear(1'b0);

        // O's evictions must come out in placement order 0,2,4,6
        move(0, 0, 0, 0, 0, 18'h00001, 1, 0);
        move(1, 1, 0, 0, 0, 18'h00009, 1, 1);
        move(0, 2, 0, 0, 0, 18'h00019, 2, 1);
        move(1, 3, 0, 0, 0, 18'h00099, 2, 2);
        move(0, 4, 0, 0, 0, 18'h00199, 3, 2);
        move(1, 5, 0, 0, 0, 18'h00999, 3, 3);
        move(0, 6, 0, 1, 0, 18'h01998, 3, 3);
        move(1, 7, 0, 1, 1, 18'h09990, 3, 3);
        move(0, 8, 0, 1, 2, 18'h19980, 3, 3);
        move(1, 0, 0, 1, 3, 18'h19902, 3, 3);
        move(0, 1, 0, 1, 4, 18'h19806, 3, 3);
        move(1, 2, 0, 1, 5, 18'h19026, 3, 3);
        move(0, 3, 0, 1, 6, 18'h18066, 3, 3);

        // clear lands on the COMMIT cycle of X@4: nothing may be committed
        @(negedge clk);
        mv_valid  = 1'b1;
        mv_player = 1'b1;
        mv_pos    = 4'd4;
        @(posedge clk);
        #1 mv_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("commit_clear_board", 32'(board), 32'd0);
        chk("commit_clear_counts", 32'({o_count, x_count}), 32'd0);
        chk("commit_clear_done", 32'({mv_done, evict_valid}), 32'd0);
        chk("commit_clear_ready", 32'(mv_ready), 32'd1);

        pulse_clear(1'b1);
        chk("clear_valid_reject", 32'(mv_reject), 32'd0);

`ifdef TURN_CHECK_EN
        chk("turn_after_clear", 32'(turn), 32'd0);
        move(1, 0, 1, 0, 0, 18'h00000, 0, 0);
        move(0, 0, 0, 0, 0, 18'h00001, 1, 0);
`else
        move(1, 0, 0, 0, 0, 18'h00002, 0, 1);
        move(0, 1, 0, 0, 0, 18'h00006, 1, 1);
`endif

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
